pong_timing_controller: RTL and testbench

Sequencer and configuration owner for the pong VGA raster timing. Drives the horizontal pixel counter and the vertical line counter and decodes hsync, vsync and the visible-area flag. Holds a shadow copy of the porch/sync/active geometry that a host can rewrite at any time; the new geometry takes effect only at a frame boundary. Sits between the game circuit (positions, video_on) and the VGA pins (hsync, vsync).

---
 rtl/pong_timing_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pong_timing_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_timing_controller.sv
// -----------------------------------------------------------------------------
// pong_timing_controller
//
// Raster sequencer for the pong VGA output. Runs the horizontal pixel counter
// and the vertical line counter and produces registered hsync/vsync,
// video_on, line_end and frame_end, all aligned with the counter values they
// describe. The porch/sync/active geometry of each axis lives in two copies:
// the active copy drives the decode, and the pending copy is rewritten by the
// host. The pending copy moves into the active one only at a frame boundary
// (or at once while the raster is stopped).
//
// Ports
//   clk_i, rst_ni          pixel clock, asynchronous active-low reset
//   enable_i               1 = raster runs, 0 = raster stopped (counters at 0)
//   cfg_valid_i, cfg_sel_i host geometry write, sel 0 = horizontal, 1 = vertical
//   cfg_active_i .. cfg_bp_i  offered geometry fields
//   cfg_ready_o            1 whenever out of reset
//   cfg_err_o              one-cycle pulse after an invalid offer was dropped
//   xposition_o, yposition_o  current pixel / line counters
//   hsync_o, vsync_o       active-low sync pulses
//   video_on_o             visible-area flag
//   line_end_o, frame_end_o  last pixel of line / last pixel of frame
// -----------------------------------------------------------------------------
module pong_timing_controller #(
  parameter int unsigned RES      = 32'd10,
  parameter int unsigned H_ACTIVE = 32'd640,
  parameter int unsigned H_FP     = 32'd16,
  parameter int unsigned H_SYNC   = 32'd96,
  parameter int unsigned H_BP     = 32'd48,
  parameter int unsigned V_ACTIVE = 32'd480,
  parameter int unsigned V_FP     = 32'd10,
  parameter int unsigned V_SYNC   = 32'd2,
  parameter int unsigned V_BP     = 32'd33
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           enable_i,
  input  logic           cfg_valid_i,
  input  logic           cfg_sel_i,
  input  logic [RES-1:0] cfg_active_i,
  input  logic [RES-1:0] cfg_fp_i,
  input  logic [RES-1:0] cfg_sync_i,
  input  logic [RES-1:0] cfg_bp_i,
  output logic           cfg_ready_o,
  output logic           cfg_err_o,
  output logic [RES-1:0] xposition_o,
  output logic [RES-1:0] yposition_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           video_on_o,
  output logic           line_end_o,
  output logic           frame_end_o
);

  // Sums are carried two bits wider than a field so four fields never overflow.
  localparam int unsigned W = RES + 32'd2;

  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [RES-1:0] ONE_R  = {{(RES-1){1'b0}}, 1'b1};
  localparam logic [RES-1:0] ZERO_R = {RES{1'b0}};
  // Largest legal axis total: 2^RES.
  localparam logic [W-1:0]   T_MAX  = {2'b01, {RES{1'b0}}};

  typedef struct packed {
    logic [RES-1:0] a;
    logic [RES-1:0] fp;
    logic [RES-1:0] sp;
    logic [RES-1:0] bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } geom_t;

  localparam geom_t GEOM_RST = '{
    h: '{a: H_ACTIVE[RES-1:0], fp: H_FP[RES-1:0], sp: H_SYNC[RES-1:0], bp: H_BP[RES-1:0]},
    v: '{a: V_ACTIVE[RES-1:0], fp: V_FP[RES-1:0], sp: V_SYNC[RES-1:0], bp: V_BP[RES-1:0]}
  };

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [W-1:0] ext(input logic [RES-1:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [W-1:0] axis_total(input axis_t g);
    return ext(g.a) + ext(g.fp) + ext(g.sp) + ext(g.bp);
  endfunction

  function automatic logic axis_valid(input axis_t g);
    logic nonzero;
    nonzero = (g.a != ZERO_R) && (g.fp != ZERO_R) && (g.sp != ZERO_R) && (g.bp != ZERO_R);
    return nonzero && (axis_total(g) <= T_MAX);
  endfunction

  // Sync window is [A+FP, A+FP+SP).
  function automatic logic in_sync(input logic [W-1:0] c, input axis_t g);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    lo = ext(g.a) + ext(g.fp);
    hi = lo + ext(g.sp);
    return (c >= lo) && (c < hi);
  endfunction

  state_t         state_q, state_d;
  logic [RES-1:0] x_q, x_d;
  logic [RES-1:0] y_q, y_d;
  geom_t          act_q, act_d;
  geom_t          pend_q, pend_d;
  logic           pend_flag_q, pend_flag_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           video_q, video_d;
  logic           line_end_q, line_end_d;
  logic           frame_end_q, frame_end_d;
  logic           cfg_err_q, cfg_err_d;
  logic           ready_q;

  axis_t          offered_s;
  logic           offer_ok_s;
  logic           write_ok_s;
  logic           x_last_s;
  logic           y_last_s;
  logic           frame_last_s;
  logic           commit_s;

  assign offered_s    = '{a: cfg_active_i, fp: cfg_fp_i, sp: cfg_sync_i, bp: cfg_bp_i};
  assign offer_ok_s   = axis_valid(offered_s);
  assign write_ok_s   = cfg_valid_i && offer_ok_s;
  assign x_last_s     = (ext(x_q) == axis_total(act_q.h) - ONE_W);
  assign y_last_s     = (ext(y_q) == axis_total(act_q.v) - ONE_W);
  // The cycle currently presenting the last pixel of the frame.
  assign frame_last_s = (state_q == ST_RUN) && x_last_s && y_last_s;
  // Stopped raster has no frame in flight, so a pending set can go live at once.
  assign commit_s     = pend_flag_q && ((state_q == ST_STOP) || frame_last_s);

  // Run/stop state transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (enable_i) state_d = ST_RUN;
        else          state_d = ST_STOP;
      end
      ST_RUN: begin
        if (enable_i) state_d = ST_RUN;
        else          state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Pixel and line counter advance; any cycle not continuing a run restarts at 0,0
  always_comb begin
    x_d = ZERO_R;
    y_d = ZERO_R;
    if ((state_q == ST_RUN) && enable_i) begin
      if (x_last_s) begin
        x_d = ZERO_R;
        if (y_last_s) y_d = ZERO_R;
        else          y_d = y_q + ONE_R;
      end else begin
        x_d = x_q + ONE_R;
        y_d = y_q;
      end
    end else begin
      x_d = ZERO_R;
      y_d = ZERO_R;
    end
  end

  // Geometry shadow update: commit reads the old pending copy, so a write in
  // the commit cycle lands after it and waits for the next frame boundary
  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    cfg_err_d   = cfg_valid_i && !offer_ok_s;
    if (commit_s) begin
      act_d       = pend_q;
      pend_flag_d = 1'b0;
    end else begin
      act_d       = act_q;
    end
    if (write_ok_s) begin
      if (cfg_sel_i) pend_d.v = offered_s;
      else           pend_d.h = offered_s;
      pend_flag_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Decode of the next counter values against the geometry live next cycle,
  // so the registered flags line up with the registered counters
  always_comb begin
    hsync_d     = 1'b1;
    vsync_d     = 1'b1;
    video_d     = 1'b0;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    if (state_d == ST_RUN) begin
      hsync_d     = !in_sync(ext(x_d), act_d.h);
      vsync_d     = !in_sync(ext(y_d), act_d.v);
      video_d     = (x_d < act_d.h.a) && (y_d < act_d.v.a);
      line_end_d  = (ext(x_d) == axis_total(act_d.h) - ONE_W);
      frame_end_d = line_end_d && (ext(y_d) == axis_total(act_d.v) - ONE_W);
    end else begin
      hsync_d     = 1'b1;
      vsync_d     = 1'b1;
      video_d     = 1'b0;
      line_end_d  = 1'b0;
      frame_end_d = 1'b0;
    end
  end

  // State, counters, geometry copies and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_STOP;
      x_q         <= ZERO_R;
      y_q         <= ZERO_R;
      act_q       <= GEOM_RST;
      pend_q      <= GEOM_RST;
      pend_flag_q <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_q     <= video_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      cfg_err_q   <= cfg_err_d;
      ready_q     <= 1'b1;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = cfg_err_q;
  assign xposition_o = x_q;
  assign yposition_o = y_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign video_on_o  = video_q;
  assign line_end_o  = line_end_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: tb/tb_pong_timing_controller.sv
// -----------------------------------------------------------------------------
// tb_pong_timing_controller
//
// Self-checking bench for pong_timing_controller. A behavioural model holds
// the raster position and both geometry copies as plain integers and predicts
// every output after every clock edge. A table of single-cycle vectors covers
// geometry validation while stopped; hand-written sequences cover the frame
// boundary commit, enable drop and asynchronous reset; a randomized phase
// mixes enable toggles and host writes.
// -----------------------------------------------------------------------------
module tb_pong_timing_controller;

  localparam int RES = 10;

  logic           clk_i  = 1'b0;
  logic           rst_ni = 1'b1;
  logic           en     = 1'b0;
  logic           cv     = 1'b0;
  logic           csel   = 1'b0;
  logic [RES-1:0] ca = 10'd0, cf = 10'd0, cs = 10'd0, cb = 10'd0;

  logic           ready, err, hs, vs, vid, le, fe;
  logic [RES-1:0] xp, yp;

  int vec_cnt = 0;
  int mis_cnt = 0;

  // Behavioural model state
  int m_run, m_x, m_y, m_flag, m_err;
  int act  [2][4];
  int pend [2][4];

  always #5 clk_i = ~clk_i;

  pong_timing_controller dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (en),
    .cfg_valid_i  (cv),
    .cfg_sel_i    (csel),
    .cfg_active_i (ca),
    .cfg_fp_i     (cf),
    .cfg_sync_i   (cs),
    .cfg_bp_i     (cb),
    .cfg_ready_o  (ready),
    .cfg_err_o    (err),
    .xposition_o  (xp),
    .yposition_o  (yp),
    .hsync_o      (hs),
    .vsync_o      (vs),
    .video_on_o   (vid),
    .line_end_o   (le),
    .frame_end_o  (fe)
  );

  function automatic int tot(input int ax);
    return act[ax][0] + act[ax][1] + act[ax][2] + act[ax][3];
  endfunction

  function automatic bit set_ok(input int a, input int f, input int s, input int b);
    return (a != 0) && (f != 0) && (s != 0) && (b != 0) && ((a + f + s + b) <= 1024);
  endfunction

  task automatic model_reset();
    act[0]  = '{640, 16, 96, 48};
    act[1]  = '{480, 10, 2, 33};
    pend    = act;
    m_run   = 0;
    m_x     = 0;
    m_y     = 0;
    m_flag  = 0;
    m_err   = 0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    int  ht, vt;
    int  off [4];
    bit  frame_done, ok, commit;
    ht         = tot(0);
    vt         = tot(1);
    frame_done = (m_run != 0) && (m_x == ht - 1) && (m_y == vt - 1);
    off        = '{int'(ca), int'(cf), int'(cs), int'(cb)};
    ok         = set_ok(off[0], off[1], off[2], off[3]);
    m_err      = (cv && !ok) ? 1 : 0;
    commit     = (m_flag != 0) && ((m_run == 0) || frame_done);
    if (commit) begin
      act    = pend;
      m_flag = 0;
    end
    if (cv && ok) begin
      pend[csel] = off;
      m_flag     = 1;
    end
    if ((m_run != 0) && en) begin
      if (m_x == ht - 1) begin
        m_x = 0;
        m_y = (m_y == vt - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end else begin
      m_x = 0;
      m_y = 0;
    end
    m_run = en ? 1 : 0;
  endtask

  task automatic check_model();
    logic [26:0] expv, gotv;
    bit e_hs, e_vs, e_vid, e_le, e_fe;
    int hl, vl;
    e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0; e_le = 1'b0; e_fe = 1'b0;
    if (m_run != 0) begin
      hl    = act[0][0] + act[0][1];
      vl    = act[1][0] + act[1][1];
      e_hs  = !((m_x >= hl) && (m_x < hl + act[0][2]));
      e_vs  = !((m_y >= vl) && (m_y < vl + act[1][2]));
      e_vid = (m_x < act[0][0]) && (m_y < act[1][0]);
      e_le  = (m_x == tot(0) - 1);
      e_fe  = e_le && (m_y == tot(1) - 1);
    end
    expv = {1'b1, m_err[0], m_x[RES-1:0], m_y[RES-1:0], e_hs, e_vs, e_vid, e_le, e_fe};
    gotv = {ready, err, xp, yp, hs, vs, vid, le, fe};
    vec_cnt++;
    if (gotv !== expv) begin
      mis_cnt++;
      if (mis_cnt <= 20)
        $display("FAIL model t=%0t got {rdy,err,x,y,hs,vs,vid,le,fe}=%b,%b,%0d,%0d,%b%b%b%b%b required %b,%b,%0d,%0d,%b%b%b%b%b",
                 $time, ready, err, xp, yp, hs, vs, vid, le, fe,
                 1'b1, m_err[0], m_x, m_y, e_hs, e_vs, e_vid, e_le, e_fe);
    end
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    vec_cnt++;
    if (actual !== expected) begin
      mis_cnt++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // One clock: edge, model update, sample away from the edge, compare.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic write_cfg(input logic sel, input int a, input int f, input int s, input int b);
    cv = 1'b1; csel = sel; ca = RES'(a); cf = RES'(f); cs = RES'(s); cb = RES'(b);
    step();
    cv = 1'b0;
  endtask

  // From the current sample up to and including the next line_end cycle.
  task automatic run_line(output int le_x, output int hs_first, output int hs_last, output int hs_cnt);
    le_x = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!hs) begin
        if (hs_first < 0) hs_first = int'(xp);
        hs_last = int'(xp);
        hs_cnt++;
      end
      if (le) begin
        le_x = int'(xp);
        break;
      end
      step();
    end
    if (le_x < 0) chk("line_end_timeout", 0, 1);
  endtask

  task automatic wait_fe(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fe) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) chk("frame_end_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int x, input int y, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((int'(xp) == x) && (int'(yp) == y)) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) chk("position_timeout", 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"},  int'(xp),  0);
    chk({tag, "_y"},  int'(yp),  0);
    chk({tag, "_hs"}, int'(hs),  1);
    chk({tag, "_vs"}, int'(vs),  1);
    chk({tag, "_fe"}, int'(fe),  0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_idle(tag);
    chk({tag, "_vid"}, int'(vid),   0);
    chk({tag, "_le"},  int'(le),    0);
    chk({tag, "_err"}, int'(err),   0);
    chk({tag, "_rdy"}, int'(ready), 0);
  endtask

  typedef struct {
    logic valid;
    logic sel;
    int   a, f, s, b;
    logic exp_err;
  } tv_t;

  tv_t tbl [9];

  initial begin
    int le_x, hf, hl, hc, nfe, fex, fey, vfirst, vlast;

    // Geometry offers while stopped: validation and last-writer-wins.
    tbl[0] = '{1'b0, 1'b0,    0,  0,  0,  0, 1'b0};
    tbl[1] = '{1'b1, 1'b0,   40,  4,  6, 10, 1'b0};
    tbl[2] = '{1'b1, 1'b0,   40,  4,  0, 10, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1000, 50, 25, 25, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1000, 10, 10,  5, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1000, 10,  9,  5, 1'b0};
    tbl[6] = '{1'b1, 1'b1,   20,  2,  2,  4, 1'b0};
    tbl[7] = '{1'b1, 1'b0,    0,  4,  6, 10, 1'b1};
    tbl[8] = '{1'b0, 1'b0,    0,  0,  0,  0, 1'b0};

    // Reset values
    model_reset();
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    step();

    // Default geometry: first two lines
    en = 1'b1;
    step();
    chk("first_x", int'(xp), 0);
    chk("first_y", int'(yp), 0);
    run_line(le_x, hf, hl, hc);
    chk("def_line_end_x", le_x, 799);
    chk("def_hs_first", hf, 656);
    chk("def_hs_last", hl, 751);
    chk("def_hs_len", hc, 96);
    for (int i = 0; i < 800; i++) step();

    // Stopped: table of offers
    en = 1'b0;
    step();
    foreach (tbl[i]) begin
      cv = tbl[i].valid; csel = tbl[i].sel;
      ca = RES'(tbl[i].a); cf = RES'(tbl[i].f); cs = RES'(tbl[i].s); cb = RES'(tbl[i].b);
      step();
      cv = 1'b0;
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].exp_err));
      chk_idle($sformatf("tbl%0d", i));
    end

    // Small geometry (60 x 28): two frames
    en = 1'b1;
    nfe = 0; fex = -1; fey = -1; vfirst = -1; vlast = -1;
    for (int i = 0; i < 3370; i++) begin
      step();
      if (fe) begin
        nfe++;
        fex = int'(xp);
        fey = int'(yp);
      end
      if (!vs && (i < 1680)) begin
        if (vfirst < 0) vfirst = int'(yp);
        vlast = int'(yp);
      end
    end
    chk("small_fe_count", nfe, 2);
    chk("small_fe_x", fex, 59);
    chk("small_fe_y", fey, 27);
    chk("small_vs_first", vfirst, 22);
    chk("small_vs_last", vlast, 23);

    // Mid-frame write: current frame keeps old lines, next frame uses new ones
    wait_pos(5, 10, 2000);
    write_cfg(1'b0, 320, 8, 48, 24);
    run_line(le_x, hf, hl, hc);
    chk("old_line_after_write", le_x, 59);
    wait_fe(2000);
    step();
    run_line(le_x, hf, hl, hc);
    chk("new_line_end_x", le_x, 399);
    chk("new_hs_first", hf, 328);
    chk("new_hs_last", hl, 375);
    chk("new_hs_len", hc, 48);

    // Write during the frame_end cycle misses that commit
    wait_fe(12000);
    write_cfg(1'b0, 40, 4, 6, 10);
    run_line(le_x, hf, hl, hc);
    chk("fe_write_unchanged", le_x, 399);
    wait_fe(12000);
    step();
    run_line(le_x, hf, hl, hc);
    chk("fe_write_applied", le_x, 59);

    // Invalid offers while running
    write_cfg(1'b0, 40, 4, 0, 10);
    chk("err_sync0", int'(err), 1);
    step();
    chk("err_sync0_clear", int'(err), 0);
    write_cfg(1'b1, 1000, 50, 25, 25);
    chk("err_1100", int'(err), 1);
    step();
    chk("err_1100_clear", int'(err), 0);
    wait_fe(2000);
    step();
    run_line(le_x, hf, hl, hc);
    chk("err_timing_kept", le_x, 59);

    // Randomized enable toggles and host writes
    for (int i = 0; i < 15000; i++) begin
      if (en) en = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
      else    en = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        cv   = 1'b1;
        csel = 1'($urandom_range(0, 1));
        ca   = RES'($urandom_range(1, 12));
        cf   = RES'($urandom_range(1, 12));
        cs   = RES'($urandom_range(1, 12));
        cb   = RES'($urandom_range(1, 12));
        if ($urandom_range(0, 4) == 0) cs = 10'd0;
        if ($urandom_range(0, 9) == 0) begin
          ca = 10'd1000; cf = 10'd20; cs = 10'd20; cb = 10'd20;
        end
      end
      step();
      cv = 1'b0;
    end

    // Enable drop mid-frame, then restart from 0,0
    en = 1'b0;
    step();
    write_cfg(1'b0, 40, 4, 6, 10);
    write_cfg(1'b1, 20, 2, 2, 4);
    step();
    en = 1'b1;
    wait_pos(30, 3, 2000);
    en = 1'b0;
    step();
    chk_idle("drop");
    en = 1'b1;
    step();
    chk("resume_x0", int'(xp), 0);
    chk("resume_y0", int'(yp), 0);
    step();
    chk("resume_x1", int'(xp), 1);

    // Asynchronous reset with a write pending
    for (int i = 0; i < 50; i++) step();
    write_cfg(1'b0, 320, 8, 48, 24);
    for (int i = 0; i < 5; i++) step();
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    run_line(le_x, hf, hl, hc);
    chk("rst_default_line", le_x, 799);
    chk("rst_default_hs_first", hf, 656);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
